// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Sequential multi-word adder/subtractor built around a single W-bit add
//   slice. Operands of W*WORDS bits are processed one word per clock, least
//   significant word first, with the inter-word carry held in a register.
//   Subtraction is a + ~b + 1: b is inverted on capture and the carry-in is
//   forced to 1 (cin is ignored).
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request a new operation (sampled only in IDLE or DONE)
//   sub    in   0: a + b + cin, 1: a - b
//   cin    in   carry-in for add mode
//   a      in   operand A (W*WORDS bits), captured on the accepting edge
//   b      in   operand B (W*WORDS bits), captured on the accepting edge
//   busy   out  high while words are being processed
//   done   out  one-cycle pulse; sum/cout/ovf valid
//   sum    out  result register; partially updated while busy
//   cout   out  carry out of the MS word (sub: 1 = no borrow)
//   ovf    out  signed overflow of the full-width operation
module multiword_add_seq #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic               cin,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int unsigned N  = W * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Captured operands; b_q already holds ~b for subtraction.
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  logic [N-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;

  // FSM control strobes
  logic accept;
  logic step;
  logic last;

  // Add slice
  logic [W-1:0]  a_w;
  logic [W-1:0]  b_w;
  logic [W:0]    add_res;
  logic          ovf_next;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here: requests during a run
        // are dropped, not queued.
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Word select and add slice
  // ---------------------------------------------------------------------
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        a_w = a_q[i*W +: W];
        b_w = b_q[i*W +: W];
      end
    end
  end

  assign add_res = {1'b0, a_w} + {1'b0, b_w} + {{W{1'b0}}, carry_q};

  // Signed overflow: operands (after inversion) agree in sign but the result
  // sign differs. Only meaningful on the MS word.
  assign ovf_next = (a_q[N-1] == b_q[N-1]) && (add_res[W-1] != a_q[N-1]);

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      idx_q   <= '0;
    end else if (step) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx_q == IW'(i)) begin
          sum_q[i*W +: W] <= add_res[W-1:0];
        end
      end
      carry_q <= add_res[W];
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        cout_q <= add_res[W];
        ovf_q  <= ovf_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
